// File: rtl/outpass4_capture_fifo_pkg.sv
// Shared constants for the OutPass capture buffer: capture modes, trigger FSM
// states and the stored entry width.
package outpass_capture_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_ALL  = 2'b01;
    localparam logic [1:0] MODE_CHG  = 2'b10;
    localparam logic [1:0] MODE_TRIG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trig_state_t;

    // Each entry is {timestamp, nibble}.
    function automatic int entry_width(input int ts_width);
        return ts_width + 4;
    endfunction

endpackage

// File: rtl/outpass4_capture_fifo_if.sv
// Valid/ready read port of the capture buffer; the buffer drives as master,
// the host/debug consumer attaches as slave.
interface outpass4_capture_fifo_if #(
    parameter int WIDTH = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/outpass4_capture_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only
// when a pop happens in the same cycle.
module capture_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the read port is forced to zero while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = o_empty ? '0 : r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/outpass4_capture_fifo.sv
// Captures the OutPass O3..O0 nibble with a free-running timestamp into a
// FIFO, under off / every-cycle / on-change / pattern-trigger modes.
module outpass4_capture_fifo
    import outpass_capture_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 12
) (
    input  logic                      UserCLK,
    input  logic                      RST,
    input  logic [3:0]                O_in,
    input  logic [1:0]                Mode,
    input  logic [3:0]                TrigPattern,
    input  logic [3:0]                TrigMask,
    input  logic                      Arm,
    input  logic                      ClearOvf,
    outpass4_capture_fifo_if.master   m_if,
    output logic [$clog2(DEPTH):0]    Level,
    output logic                      Overflow,
    output logic                      Triggered
);
    localparam int EW = entry_width(TS_WIDTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LAST_CNT = LW'(DEPTH - 1);

    logic [3:0]          r_s_q;
    logic [3:0]          r_s_prev;
    logic [1:0]          r_mode_q;
    logic                r_first;
    logic [TS_WIDTH-1:0] r_ts;
    trig_state_t         r_state;
    trig_state_t         w_state_nxt;
    logic [LW-1:0]       r_cap_cnt;
    logic [LW-1:0]       w_cap_cnt_nxt;
    logic                r_ovf;
    logic                r_trig;
    logic                w_trig_nxt;
    logic                w_match;
    logic                w_cap;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    logic [EW-1:0]       w_dout;
    logic [LW-1:0]       w_level;

    // Mode is registered with the sample so every decision sees the mode
    // that was in force when that sample was taken.
    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_s_q    <= '0;
            r_s_prev <= '0;
            r_mode_q <= MODE_OFF;
            r_first  <= 1'b1;
            r_ts     <= '0;
        end else begin
            r_s_q    <= O_in;
            r_s_prev <= r_s_q;
            r_mode_q <= Mode;
            if (Mode != r_mode_q)
                r_first <= 1'b1;
            else if (r_mode_q == MODE_CHG)
                r_first <= 1'b0;
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    assign w_match = (((r_s_q ^ TrigPattern) & TrigMask) == 4'b0000);
    assign w_pop   = ~w_empty & m_if.m_ready;

    always_comb begin
        w_cap = 1'b0;
        case (r_mode_q)
            MODE_ALL:  w_cap = 1'b1;
            MODE_CHG:  w_cap = (r_s_q != r_s_prev) | r_first;
            MODE_TRIG: w_cap = (r_state == ST_CAPTURE) | ((r_state == ST_ARMED) & w_match);
            default:   w_cap = 1'b0;
        endcase
    end

    assign w_push = w_cap & (~w_full | w_pop);
    assign w_drop = w_cap & w_full & ~w_pop;

    // The matching sample counts as the first of the DEPTH captured entries.
    always_comb begin
        w_state_nxt   = r_state;
        w_cap_cnt_nxt = r_cap_cnt;
        w_trig_nxt    = r_trig;
        if (r_mode_q != MODE_TRIG) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (Arm) begin
                        w_state_nxt   = ST_ARMED;
                        w_trig_nxt    = 1'b0;
                        w_cap_cnt_nxt = '0;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (w_cap) begin
                        if (w_drop || (r_cap_cnt == LAST_CNT)) begin
                            w_state_nxt = ST_DONE;
                            w_trig_nxt  = 1'b1;
                        end else begin
                            w_state_nxt   = ST_CAPTURE;
                            w_cap_cnt_nxt = r_cap_cnt + LW'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cap_cnt <= '0;
            r_trig    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cap_cnt <= w_cap_cnt_nxt;
            r_trig    <= w_trig_nxt;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ClearOvf)
                r_ovf <= 1'b0;
        end
    end

    capture_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .i_clk   (UserCLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({r_ts, r_s_q}),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_level)
    );

    assign m_if.m_valid = ~w_empty;
    assign m_if.m_data  = w_dout;
    assign Level        = w_level;
    assign Overflow     = r_ovf;
    assign Triggered    = r_trig;

endmodule

// File: tb/tb_outpass4_capture_fifo.sv
// Bench for outpass4_capture_fifo: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_outpass4_capture_fifo;
    import outpass_capture_pkg::*;

    localparam int DEPTH = 16;
    localparam int TSW   = 12;
    localparam int TSW4  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] o_in;
    logic [1:0] mode;
    logic [3:0] pat;
    logic [3:0] mask;
    logic       arm;
    logic       clr;
    logic       rdy;
    logic [4:0] level;
    logic [4:0] level4;
    logic       ovf;
    logic       ovf4;
    logic       trg;
    logic       trg4;

    always #5 clk = ~clk;

    outpass4_capture_fifo_if #(.WIDTH(TSW + 4))  bus ();
    outpass4_capture_fifo_if #(.WIDTH(TSW4 + 4)) bus4 ();
    assign bus.m_ready  = rdy;
    assign bus4.m_ready = rdy;

    outpass4_capture_fifo #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .UserCLK(clk), .RST(rst), .O_in(o_in), .Mode(mode), .TrigPattern(pat),
        .TrigMask(mask), .Arm(arm), .ClearOvf(clr), .m_if(bus),
        .Level(level), .Overflow(ovf), .Triggered(trg)
    );

    outpass4_capture_fifo #(.DEPTH(DEPTH), .TS_WIDTH(TSW4)) dut4 (
        .UserCLK(clk), .RST(rst), .O_in(o_in), .Mode(mode), .TrigPattern(pat),
        .TrigMask(mask), .Arm(arm), .ClearOvf(clr), .m_if(bus4),
        .Level(level4), .Overflow(ovf4), .Triggered(trg4)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of {ts, nibble}, sample history, trigger phase.
    int unsigned mq[$];
    int unsigned m_ts;
    logic [3:0]  m_sq, m_sprev;
    logic [1:0]  m_mode, m_pmode;
    int          m_phase;   // 0 idle, 1 armed, 2 capturing, 3 done
    int          m_written;
    bit          m_ovf, m_trg;
    int unsigned plog[$];
    int unsigned plog4[$];

    task automatic model_step();
        bit pop, full, cap, push, drop, match;
        if (rst) begin
            mq.delete();
            m_ts = 0; m_sq = 0; m_sprev = 0; m_mode = 0; m_pmode = 0;
            m_phase = 0; m_written = 0; m_ovf = 0; m_trg = 0;
            return;
        end
        pop   = (mq.size() > 0) && rdy;
        full  = (mq.size() == DEPTH);
        match = ((m_sq & mask) == (pat & mask));
        cap   = 0;
        case (m_mode)
            2'b01:   cap = 1;
            2'b10:   cap = (m_sq != m_sprev) || (m_mode != m_pmode);
            2'b11:   cap = (m_phase == 2) || (m_phase == 1 && match);
            default: cap = 0;
        endcase
        push = cap && (!full || pop);
        drop = cap && full && !pop;
        if (m_mode != 2'b11) begin
            m_phase = 0;
        end else if ((m_phase == 0 || m_phase == 3) && arm) begin
            m_phase = 1; m_trg = 0; m_written = 0;
        end else if (cap) begin
            if (push) m_written++;
            if (drop || m_written == DEPTH) begin
                m_phase = 3; m_trg = 1;
            end else begin
                m_phase = 2;
            end
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back((m_ts << 4) | 32'(m_sq));
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_ts    = (m_ts + 1) % 4096;
        m_pmode = m_mode;
        m_mode  = mode;
        m_sprev = m_sq;
        m_sq    = o_in;
    endtask

    task automatic compare_all();
        int unsigned e;
        chk("valid",  32'(bus.m_valid),  32'(mq.size() > 0));
        chk("level",  32'(level),        32'(mq.size()));
        chk("ovf",    32'(ovf),          32'(m_ovf));
        chk("trig",   32'(trg),          32'(m_trg));
        chk("valid4", 32'(bus4.m_valid), 32'(mq.size() > 0));
        chk("level4", 32'(level4),       32'(mq.size()));
        if (mq.size() > 0) begin
            e = mq[0];
            chk("data",  32'(bus.m_data),  e & 32'hFFFF);
            chk("data4", 32'(bus4.m_data), (((e >> 4) & 15) << 4) | (e & 15));
        end
    endtask

    task automatic tick();
        if (bus.m_valid && rdy)  plog.push_back(32'(bus.m_data));
        if (bus4.m_valid && rdy) plog4.push_back(32'(bus4.m_data));
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned ts0, d;
        int rdy_pct;
        bit wrapped;
        rst = 1; o_in = 0; mode = 2'b00; pat = 0; mask = 0; arm = 0; clr = 0; rdy = 0;
        ticks(3);
        rst = 0;
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_data",  32'(bus.m_data),  32'd0);
        chk("rst_level", 32'(level),       32'd0);
        chk("rst_ovf",   32'(ovf),         32'd0);
        chk("rst_trig",  32'(trg),         32'd0);
        ticks(3);

        // Every-cycle capture, two-cycle latency, consecutive timestamps.
        mode = 2'b01; o_in = 4'h1; rdy = 1;
        tick();
        chk("t2_lat1", 32'(bus.m_valid), 32'd0);
        o_in = 4'h2; tick();
        chk("t2_lat2", 32'(bus.m_valid), 32'd1);
        chk("t2_nib1", 32'(bus.m_data[3:0]), 32'd1);
        ts0 = 32'(bus.m_data[15:4]);
        o_in = 4'h3; tick();
        chk("t2_nib2", 32'(bus.m_data[3:0]), 32'd2);
        chk("t2_ts2",  32'(bus.m_data[15:4]), (ts0 + 1) % 4096);
        mode = 2'b00; tick();
        chk("t2_nib3", 32'(bus.m_data[3:0]), 32'd3);
        chk("t2_ts3",  32'(bus.m_data[15:4]), (ts0 + 2) % 4096);
        ticks(3);

        // On-change capture.
        plog.delete();
        mode = 2'b10;
        o_in = 4'hA; ticks(3);
        o_in = 4'h5; ticks(6);
        mode = 2'b00; ticks(4);
        chk("t3_count", 32'(plog.size()), 32'd2);
        if (plog.size() == 2) begin
            chk("t3_nib0", plog[0] & 15, 32'hA);
            chk("t3_nib1", plog[1] & 15, 32'h5);
            chk("t3_dts",  ((plog[1] >> 4) - (plog[0] >> 4)) % 4096, 32'd3);
        end

        // Fill, overflow, pop+push while full, ClearOvf, set-wins.
        mode = 2'b01; rdy = 0; ticks(20);
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_ovf",   32'(ovf),   32'd1);
        rdy = 1; tick();
        chk("t4_pp_level", 32'(level), 32'd16);
        clr = 1; tick(); clr = 0;
        chk("t4_clr", 32'(ovf), 32'd0);
        rdy = 0; ticks(3);
        clr = 1; tick(); clr = 0;
        chk("t4_setwins", 32'(ovf), 32'd1);
        mode = 2'b00; rdy = 1; ticks(20);
        clr = 1; tick(); clr = 0;

        // Pattern trigger.
        mode = 2'b11; mask = 4'b1100; pat = 4'b1000; o_in = 4'b0011; rdy = 0;
        ticks(3);
        chk("t5_pre_trig", 32'(trg), 32'd0);
        arm = 1; tick(); arm = 0;
        tick();
        o_in = 4'b1011; tick();
        for (int i = 0; i < 20; i++) begin
            o_in = 4'($urandom);
            tick();
        end
        chk("t5_level", 32'(level), 32'd16);
        chk("t5_trig",  32'(trg),   32'd1);
        chk("t5_head",  32'(bus.m_data[3:0]), 32'b1011);

        // Reset held three cycles with the buffer full and Triggered set.
        mode = 2'b01; rdy = 0; ticks(4);
        rst = 1; ticks(3); rst = 0;
        chk("t1_valid", 32'(bus.m_valid), 32'd0);
        chk("t1_level", 32'(level),       32'd0);
        chk("t1_ovf",   32'(ovf),         32'd0);
        chk("t1_trig",  32'(trg),         32'd0);
        mode = 2'b00; ticks(3);

        // Narrow timestamp wraps 15 -> 0.
        plog4.delete();
        mode = 2'b01; rdy = 1; ticks(22);
        mode = 2'b00; ticks(4);
        wrapped = 0;
        for (int i = 1; i < plog4.size(); i++) begin
            d = ((plog4[i] >> 4) - (plog4[i-1] >> 4)) & 15;
            chk("t6_dts", d, 32'd1);
            if ((plog4[i-1] >> 4) == 15 && (plog4[i] >> 4) == 0) wrapped = 1;
        end
        chk("t6_wrap", 32'(wrapped), 32'd1);

        // Random traffic.
        rdy_pct = 50;
        for (int i = 0; i < 5000; i++) begin
            if (i % 200 == 0) rdy_pct = $urandom_range(5, 95);
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) o_in = 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                mask = 4'($urandom);
                pat  = 4'($urandom);
            end
            rdy = ($urandom_range(0, 99) < rdy_pct);
            arm = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 0; arm = 0; clr = 0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
